drip_pulse_emitter: RTL and testbench

- Counterpart of the drip tens/units counter: that block turns sensed drip pulses into a BCD count. This block takes a two-digit BCD drip count and emits that many timed valve pulses.
- Sits between the irrigation controller, which supplies the preset and start, and the drip valve driver.
- Exposes the remaining count as BCD digits so the existing 7-segment display path can show it.

---
 rtl/drip_pulse_emitter.sv | 146 ++++++++++++++
 tb/tb_drip_pulse_emitter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/drip_pulse_emitter.sv
// Emits a preset number of timed valve pulses from a two-digit BCD drip count,
// exposing the remaining count as BCD. Define DRIP_PAUSE_EN to add a pause input.
module drip_pulse_emitter #(
    parameter int PULSE_HIGH = 4,
    parameter int PULSE_LOW  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
`ifdef DRIP_PAUSE_EN
    input  logic       pause,
`endif
    input  logic [3:0] tens_bcd,
    input  logic [3:0] units_bcd,
    output logic       valve,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] rem_tens,
    output logic [3:0] rem_units
);

    localparam logic [7:0] HIGH_LAST = 8'(PULSE_HIGH - 1);
    localparam logic [7:0] LOW_LAST  = 8'(PULSE_LOW - 1);

    // Handshake: start is a level sampled only in IDLE; busy high means a
    // sequence is running and start is ignored; done/err are one-cycle pulses.
    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t     state;
    logic [7:0] phase;
    logic       paused;
    logic       last_drip;
    logic       preset_bad;
    logic       preset_zero;

`ifdef DRIP_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    assign last_drip   = (rem_tens == 4'd0) && (rem_units == 4'd1);
    assign preset_bad  = (tens_bcd > 4'd9) || (units_bcd > 4'd9);
    assign preset_zero = (tens_bcd == 4'd0) && (units_bcd == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            phase     <= 8'd0;
            valve     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rem_tens  <= 4'd0;
            rem_units <= 4'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    valve <= 1'b0;
                    busy  <= 1'b0;
                    if (start && !abort) begin
                        if (preset_bad) begin
                            err <= 1'b1;
                        end else if (preset_zero) begin
                            rem_tens  <= 4'd0;
                            rem_units <= 4'd0;
                            state     <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            rem_tens  <= tens_bcd;
                            rem_units <= units_bcd;
                            phase     <= 8'd0;
                            state     <= S_HIGH;
                            valve     <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (abort) begin
                        state <= S_IDLE;
                        valve <= 1'b0;
                        busy  <= 1'b0;
                    end else if (paused) begin
                        valve <= 1'b0;
                    end else if (phase == HIGH_LAST) begin
                        // BCD decrement with borrow; the count never goes below 00.
                        if (rem_units == 4'd0) begin
                            rem_units <= 4'd9;
                            rem_tens  <= rem_tens - 4'd1;
                        end else begin
                            rem_units <= rem_units - 4'd1;
                        end
                        phase <= 8'd0;
                        valve <= 1'b0;
                        if (last_drip) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_LOW;
                        end
                    end else begin
                        phase <= phase + 8'd1;
                        valve <= 1'b1;
                    end
                end
                S_LOW: begin
                    valve <= 1'b0;
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (!paused) begin
                        if (phase == LOW_LAST) begin
                            phase <= 8'd0;
                            state <= S_HIGH;
                            valve <= 1'b1;
                        end else begin
                            phase <= phase + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    valve <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    valve <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drip_pulse_emitter.sv
// Directed bench for drip_pulse_emitter (PULSE_HIGH=4, PULSE_LOW=4): vector
// table for the 03 sequence and idle cases, hand sequences for multi-cycle corners.
module tb_drip_pulse_emitter;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       pause;
    logic [3:0] tens_bcd;
    logic [3:0] units_bcd;
    logic       valve;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] rem_tens;
    logic [3:0] rem_units;
    logic [11:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    assign outs = {valve, busy, done, err, rem_tens, rem_units};

    drip_pulse_emitter #(.PULSE_HIGH(4), .PULSE_LOW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
`ifdef DRIP_PAUSE_EN
        .pause     (pause),
`endif
        .tens_bcd  (tens_bcd),
        .units_bcd (units_bcd),
        .valve     (valve),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rem_tens  (rem_tens),
        .rem_units (rem_units)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       start;
        logic       abort;
        logic [3:0] tens;
        logic [3:0] units;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] ex(input logic v, input logic b, input logic d,
                                       input logic e, input logic [3:0] t, input logic [3:0] u);
        return {v, b, d, e, t, u};
    endfunction

    function automatic vec_t mk(input string nm, input logic st, input logic ab,
                                input logic [3:0] t, input logic [3:0] u, input logic [11:0] e);
        vec_t r;
        r.name = nm; r.start = st; r.abort = ab; r.tens = t; r.units = u; r.exp = e;
        return r;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_start(input logic [3:0] t, input logic [3:0] u);
        start = 1'b1; tens_bcd = t; units_bcd = u;
        tick();
        start = 1'b0; tens_bcd = 4'd7; units_bcd = 4'd7;
    endtask

    initial begin
        int cyc;
        int rises;
        int highs;
        int done_cyc;
        logic prev_v;
        logic saw_done;
        logic v;
        logic [3:0] ru;

        reset = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
        tens_bcd = 4'd0; units_bcd = 4'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs", outs, 12'h000);
        reset = 1'b1;
        @(negedge clk);

        // vector table: invalid preset, preset 03 run (start at edge 0), zero preset, start+abort
        vecs.push_back(mk("idle", 0, 0, 4'd0, 4'd0, ex(0, 0, 0, 0, 4'd0, 4'd0)));
        vecs.push_back(mk("bad_tens", 1, 0, 4'd10, 4'd0, ex(0, 0, 0, 1, 4'd0, 4'd0)));
        vecs.push_back(mk("err_clear", 0, 0, 4'd0, 4'd0, ex(0, 0, 0, 0, 4'd0, 4'd0)));
        for (int c = 1; c <= 22; c++) begin
            v  = (c >= 1 && c <= 4) || (c >= 9 && c <= 12) || (c >= 17 && c <= 20);
            ru = (c <= 4) ? 4'd3 : (c <= 12) ? 4'd2 : (c <= 20) ? 4'd1 : 4'd0;
            vecs.push_back(mk($sformatf("run03_c%0d", c), (c == 1) || (c == 6), 0,
                              (c == 1) ? 4'd0 : 4'd9, (c == 1) ? 4'd3 : 4'd9,
                              ex(v, c <= 20, c == 21, 0, 4'd0, ru)));
        end
        vecs.push_back(mk("zero_preset", 1, 0, 4'd0, 4'd0, ex(0, 0, 1, 0, 4'd0, 4'd0)));
        vecs.push_back(mk("zero_after", 0, 0, 4'd0, 4'd0, ex(0, 0, 0, 0, 4'd0, 4'd0)));
        vecs.push_back(mk("start_abort", 1, 1, 4'd0, 4'd5, ex(0, 0, 0, 0, 4'd0, 4'd0)));
        vecs.push_back(mk("start_abort_after", 0, 0, 4'd0, 4'd5, ex(0, 0, 0, 0, 4'd0, 4'd0)));

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; abort = vecs[i].abort;
            tens_bcd = vecs[i].tens; units_bcd = vecs[i].units;
            tick();
            check(vecs[i].name, outs, vecs[i].exp);
        end
        start = 1'b0; abort = 1'b0;

        // borrow: preset 10, done expected in cycle 1+10*4+9*4 = 77
        do_start(4'd1, 4'd0);
        cyc = 1; rises = 1; highs = 1; prev_v = valve; done_cyc = -1;
        while (cyc < 200 && done_cyc < 0) begin
            tick();
            cyc++;
            if (valve) highs++;
            if (valve && !prev_v) rises++;
            prev_v = valve;
            if (cyc == 5) check("borrow_rem", {rem_tens, rem_units}, 12'h009);
            if (done) begin
                done_cyc = cyc;
                check("borrow_done_outs", outs, ex(0, 0, 1, 0, 4'd0, 4'd0));
            end
        end
        check_int("borrow_done_cycle", done_cyc, 77);
        check_int("borrow_rises", rises, 10);
        check_int("borrow_high_cycles", highs, 40);
        tick();

        // abort during second LOW of preset 05 (LOW cycles 13-16)
        do_start(4'd0, 4'd5);
        repeat (13) tick();
        check("abort_pre", outs, ex(0, 1, 0, 0, 4'd0, 4'd3));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_post", outs, ex(0, 0, 0, 0, 4'd0, 4'd3));
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || valve || busy) saw_done = 1'b1;
        end
        check_int("abort_no_activity", int'(saw_done), 0);
        start = 1'b1; tens_bcd = 4'd10; units_bcd = 4'd2;
        tick();
        start = 1'b0;
        check("bad_keeps_rem", outs, ex(0, 0, 0, 1, 4'd0, 4'd3));
        tick();
        check("bad_err_pulse", outs, ex(0, 0, 0, 0, 4'd0, 4'd3));

        // asynchronous reset mid-HIGH with preset 23
        do_start(4'd2, 4'd3);
        tick();
        check("pre_reset_high", outs, ex(1, 1, 0, 0, 4'd2, 4'd3));
        #2 reset = 1'b0;
        #1 check("async_reset", outs, 12'h000);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();
        check("reset_stays_idle", outs, 12'h000);

`ifdef DRIP_PAUSE_EN
        // preset 02, pause seen by 6 edges from the 2nd HIGH cycle: done 13 -> 19
        do_start(4'd0, 4'd2);
        cyc = 1; highs = 1; done_cyc = -1;
        while (cyc < 100 && done_cyc < 0) begin
            pause = (cyc >= 2 && cyc <= 7);
            tick();
            cyc++;
            if (valve) highs++;
            if (cyc >= 3 && cyc <= 8 && valve) check_int("pause_valve_low", int'(valve), 0);
            if (cyc >= 3 && cyc <= 8 && !busy) check_int("pause_busy", int'(busy), 1);
            if (done) done_cyc = cyc;
        end
        pause = 1'b0;
        check_int("pause_done_cycle", done_cyc, 19);
        check_int("pause_high_cycles", highs, 8);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
